// File: rtl/acc_sched_pkg.sv
// Shared types for the PE-column accumulator sequencer (acc_sched).
// Holds the FSM state encoding used by the top and the bench.
package acc_sched_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/acc_sched_if.sv
// Job/product/result handshake bundle between an acc_sched instance and its
// controller, product source, accumulator and result sink.
interface acc_sched_if #(
  parameter int K_W    = 8,
  parameter int PERF_W = 32
);
  logic              start;
  logic [K_W-1:0]    cfg_k;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic              acc_en;
  logic              acc_clr;
  logic              busy;
  logic              o_valid;
  logic              o_ready;
  logic [PERF_W-1:0] stall_cnt;

  // Sequencer side
  modport slave (
    input  start, cfg_k, abort, in_valid, o_ready,
    output in_ready, acc_en, acc_clr, busy, o_valid, stall_cnt
  );

  // Controller / environment side
  modport master (
    output start, cfg_k, abort, in_valid, o_ready,
    input  in_ready, acc_en, acc_clr, busy, o_valid, stall_cnt
  );
endinterface

// File: rtl/acc_sched_cnt.sv
// Product counter for acc_sched: K_W-wide up counter with synchronous clear
// and a "this is the last product" compare against the job length.
module acc_sched_cnt #(
  parameter int K_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           inc,
  input  logic [K_W-1:0] lim,
  output logic [K_W-1:0] cnt,
  output logic           last
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Compared before the increment, so the counter never needs to wrap.
  assign last = (cnt == (lim - 1'b1));

endmodule

// File: rtl/acc_sched.sv
// Accumulator sequencer for one PE column: clear, admit cfg_k products, hold
// the sum for an output handshake. Optional stall counter: ACC_SCHED_PERF_EN.
module acc_sched
  import acc_sched_pkg::*;
#(
  parameter int K_W    = 8,
  parameter int PERF_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  acc_sched_if.slave  bus
);

  state_t         state;
  logic [K_W-1:0] k_q;
  logic [K_W-1:0] cnt;
  logic           last;
  logic           in_ready_w;
  logic           fire;
  logic           start_ok;
  logic           job_start;

  assign in_ready_w = (state == ACCUM) && !bus.abort;
  assign fire       = bus.in_valid && in_ready_w;

  // A new job is taken from IDLE or on the DRAIN handshake; abort beats start.
  assign start_ok  = bus.start && (bus.cfg_k != '0) && !bus.abort;
  assign job_start = start_ok &&
                     ((state == IDLE) || ((state == DRAIN) && bus.o_ready));

  acc_sched_cnt #(.K_W(K_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.abort || job_start),
    .inc   (fire),
    .lim   (k_q),
    .cnt   (cnt),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k_q   <= '0;
    end else begin
      if (job_start) begin
        k_q <= bus.cfg_k;
      end
      if (bus.abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE:    if (job_start) state <= CLEAR;
          CLEAR:   state <= ACCUM;
          ACCUM:   if (fire && last) state <= DRAIN;
          DRAIN:   if (bus.o_ready) state <= job_start ? CLEAR : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready = in_ready_w;
  assign bus.acc_en   = fire;
  assign bus.acc_clr  = (state == CLEAR) || bus.abort;
  assign bus.busy     = (state != IDLE);
  assign bus.o_valid  = (state == DRAIN);

`ifdef ACC_SCHED_PERF_EN
  logic [PERF_W-1:0] stall_q;

  // Saturating count of starved ACCUM cycles; abort neither clears nor freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (job_start) begin
      stall_q <= '0;
    end else if ((state == ACCUM) && !bus.in_valid && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_acc_sched.sv
// Bench for acc_sched: per-cycle decode checks from the stimulus thread, and a
// scoreboard of expected dot-product sums popped on each output handshake.
module tb_acc_sched;

  localparam int K_W    = 8;
  localparam int PERF_W = 32;

  // {acc_clr, acc_en, in_ready, busy, o_valid}
  localparam logic [4:0] S_IDLE = 5'b00000;
  localparam logic [4:0] S_CLR  = 5'b10010;
  localparam logic [4:0] S_ACC  = 5'b01110;
  localparam logic [4:0] S_WAIT = 5'b00110;
  localparam logic [4:0] S_DRN  = 5'b00011;
  localparam logic [4:0] S_ABTI = 5'b10000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [31:0] acc_model;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  acc_sched_if #(.K_W(K_W), .PERF_W(PERF_W)) bus ();

  acc_sched #(.K_W(K_W), .PERF_W(PERF_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Column accumulator driven by the sequencer's en/clr.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           acc_model <= '0;
    else if (bus.acc_clr) acc_model <= '0;
    else if (bus.acc_en)  acc_model <= acc_model + in_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result monitor: every output handshake must match the next queued sum.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.o_valid === 1'b1 && bus.o_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got %0d expected none", acc_model);
      end else begin
        check("result_sum", 64'(acc_model), 64'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [4:0] outv();
    return {bus.acc_clr, bus.acc_en, bus.in_ready, bus.busy, bus.o_valid};
  endfunction

  // Called at posedge+1: drive inputs, check decode at negedge, return at next posedge+1.
  task automatic cyc(input logic st, input logic [K_W-1:0] k, input logic ab,
                     input logic iv, input logic ordy, input logic [31:0] d,
                     input logic [4:0] exp, input string name);
    bus.start    = st;
    bus.cfg_k    = k;
    bus.abort    = ab;
    bus.in_valid = iv;
    bus.o_ready  = ordy;
    in_data      = d;
    @(negedge clk);
    check(name, 64'(outv()), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_stall;
  logic        t3_v[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] t3_d[6] = '{32'd5, 32'd99, 32'd99, 32'd6, 32'd99, 32'd7};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.cfg_k    = '0;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    bus.o_ready  = 1'b0;
    in_data      = '0;
    #3;
    check("reset_outputs", 64'(outv()), 64'(S_IDLE));
    check("reset_stall", 64'(bus.stall_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Test 1: asynchronous reset while in ACCUM with cnt=3.
    cyc(1, 8'd6, 0, 0, 0, 0, S_IDLE, "t1_start");
    cyc(0, 8'd6, 0, 0, 0, 0, S_CLR,  "t1_clear");
    for (int i = 0; i < 3; i++) cyc(0, 8'd0, 0, 1, 0, 32'd1, S_ACC, "t1_fire");
    bus.in_valid = 1'b1;
    #1;
    check("t1_pre_reset", 64'(outv()), 64'(S_ACC));
    rst_n = 1'b0;
    #1;
    check("t1_async_reset", 64'(outv()), 64'(S_IDLE));
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 8'd0, 0, 0, 0, 0, S_IDLE, "t1_idle_after");

    // Test 2: K=4, continuous valid, products 1..4.
    exp_q.push_back(32'd10);
    cyc(1, 8'd4, 0, 1, 0, 32'd9, S_IDLE, "t2_c0_idle");
    cyc(0, 8'd4, 0, 1, 0, 32'd9, S_CLR,  "t2_c1_clr");
    for (int i = 1; i <= 4; i++) cyc(0, 8'd4, 0, 1, 0, 32'(i), S_ACC, "t2_fire");
    cyc(0, 8'd0, 0, 0, 1, 0, S_DRN,  "t2_c6_drain");
    cyc(0, 8'd0, 0, 0, 0, 0, S_IDLE, "t2_c7_idle");

    // Test 3: K=3 with bubbles; late cfg_k change and a stray start are ignored.
    exp_q.push_back(32'd18);
    cyc(1, 8'd3, 0, 0, 0, 0, S_IDLE, "t3_start");
    cyc(0, 8'd7, 0, 0, 0, 0, S_CLR,  "t3_clear");
    for (int i = 0; i < 6; i++)
      cyc(i == 1, 8'd7, 0, t3_v[i], 0, t3_d[i], t3_v[i] ? S_ACC : S_WAIT, "t3_accum");
`ifdef ACC_SCHED_PERF_EN
    exp_stall = 32'd3;
`else
    exp_stall = 32'd0;
`endif
    check("t3_stall_cnt", 64'(bus.stall_cnt), 64'(exp_stall));
    cyc(0, 8'd0, 0, 0, 0, 0, S_DRN,  "t3_drain_wait");
    cyc(0, 8'd0, 0, 0, 1, 0, S_DRN,  "t3_drain");
    cyc(0, 8'd0, 0, 0, 0, 0, S_IDLE, "t3_idle");

    // Test 4: DRAIN stalled 5 cycles, then back-to-back job with no IDLE bubble.
    exp_q.push_back(32'd30);
    cyc(1, 8'd2, 0, 0, 0, 0, S_IDLE, "t4_start");
    cyc(0, 8'd0, 0, 0, 0, 0, S_CLR,  "t4_clear");
    cyc(0, 8'd0, 0, 1, 0, 32'd10, S_ACC, "t4_fire");
    cyc(0, 8'd0, 0, 1, 0, 32'd20, S_ACC, "t4_fire");
    for (int i = 0; i < 5; i++) cyc(0, 8'd0, 0, 0, 0, 0, S_DRN, "t4_hold");
    exp_q.push_back(32'd2);
    cyc(1, 8'd2, 0, 0, 1, 0, S_DRN, "t4_handshake_start");
    cyc(0, 8'd0, 0, 1, 0, 32'd50, S_CLR, "t4_b2b_clear");
    cyc(0, 8'd0, 0, 1, 0, 32'd1, S_ACC, "t4_b_fire");
    cyc(0, 8'd0, 0, 1, 0, 32'd1, S_ACC, "t4_b_fire");
    cyc(0, 8'd0, 0, 0, 1, 0, S_DRN,  "t4_b_drain");
    cyc(0, 8'd0, 0, 0, 0, 0, S_IDLE, "t4_idle");

    // Test 5: abort in ACCUM beats start and in_valid.
    cyc(1, 8'd5, 0, 0, 0, 0, S_IDLE, "t5_start");
    cyc(0, 8'd0, 0, 0, 0, 0, S_CLR,  "t5_clear");
    cyc(0, 8'd0, 0, 1, 0, 32'd3, S_ACC, "t5_fire");
    cyc(0, 8'd0, 0, 1, 0, 32'd3, S_ACC, "t5_fire");
    cyc(1, 8'd3, 1, 1, 0, 32'd50, S_CLR, "t5_abort");
    cyc(0, 8'd0, 0, 0, 0, 0, S_IDLE, "t5_idle");
    cyc(0, 8'd0, 1, 0, 0, 0, S_ABTI, "t5_abort_idle");
    cyc(0, 8'd0, 0, 0, 0, 0, S_IDLE, "t5_idle2");

    // Test 6: cfg_k=0 ignored, then maximal K=255 job.
    cyc(1, 8'd0, 0, 0, 0, 0, S_IDLE, "t6_k0_start");
    cyc(0, 8'd0, 0, 0, 0, 0, S_IDLE, "t6_k0_ignored");
    exp_q.push_back(32'd255);
    cyc(1, 8'd255, 0, 1, 0, 32'd1, S_IDLE, "t6_start");
    cyc(0, 8'd255, 0, 1, 0, 32'd1, S_CLR,  "t6_clear");
    for (int i = 0; i < 255; i++) cyc(0, 8'd0, 0, 1, 0, 32'd1, S_ACC, "t6_fire");
    cyc(0, 8'd0, 0, 1, 1, 32'd1, S_DRN,  "t6_drain");
    cyc(0, 8'd0, 0, 0, 0, 0, S_IDLE, "t6_idle");

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
